// File: rtl/bank_dispatch_queue_pkg.sv
// Shared types for the bank dispatch queue: request type encoding and the
// default-width bank entry layout.
package types_def;

  localparam int DQ_W  = 16;
  localparam int IDX_W = 6;
  localparam int RA_W  = 16;
  localparam int CA_W  = 10;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } r_type;

  typedef struct packed {
    logic [DQ_W-1:0]  dq;
    logic [IDX_W-1:0] idx;
    logic [RA_W-1:0]  ra;
    logic [CA_W-1:0]  ca;
    r_type            t;
  } bank_entry_t;

endpackage

// File: rtl/bank_dispatch_queue_fifo.sv
// Show-ahead FIFO for one bank. The head holds its last value once the FIFO
// drains, so the scheduler never sees head fields collapse to garbage.
module bank_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic [WIDTH-1:0] holdHead_q;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra MSB so full and empty differ only by the wrap bit.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign head_o  = empty_o ? holdHead_q : mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      holdHead_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= data_i;
        wrPtr_q                <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      holdHead_q <= head_o;
    end
  end

endmodule

// File: rtl/bank_dispatch_queue.sv
// Host request dispatcher: decodes bank/row/column, allocates sequential tags
// and queues into per-bank FIFOs. BANK_DISPATCH_TAG_ERR_EN adds tag_err_o.
module bank_dispatch_queue
  import types_def::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int DEPTH     = 4,
  parameter int CA        = 10,
  parameter int RA        = 16,
  parameter int DQ        = 16,
  parameter int IDX       = 6,
  localparam int BA       = $clog2(NUM_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_request_type,
  input  logic [DQ-1:0]           in_request_data,
  input  logic [RA+BA+CA-1:0]     in_request_address,
  output logic                    out_busy,
  input  logic                    request_done_valid,
  input  logic [IDX-1:0]          index,
  input  logic [NUM_BANKS-1:0]    ready,
  output logic [NUM_BANKS-1:0]    valid_o,
  output logic [NUM_BANKS*DQ-1:0] dq_o,
  output logic [NUM_BANKS*IDX-1:0] idx_o,
  output logic [NUM_BANKS*RA-1:0] ra_o,
  output logic [NUM_BANKS*CA-1:0] ca_o,
`ifdef BANK_DISPATCH_TAG_ERR_EN
  output logic [NUM_BANKS-1:0]    t_o,
  output logic                    tag_err_o
`else
  output logic [NUM_BANKS-1:0]    t_o
`endif
);

  localparam int EW = DQ + IDX + RA + CA + 1;

  logic [BA-1:0]        reqBank;
  logic [CA-1:0]        reqCa;
  logic [RA-1:0]        reqRa;
  r_type                reqType;
  logic [EW-1:0]        reqEntry;
  logic                 accept;
  logic [NUM_BANKS-1:0] fifoFull;
  logic [NUM_BANKS-1:0] fifoEmpty;
  logic [EW-1:0]        head [NUM_BANKS];

  logic [2**IDX-1:0]    inUse_q, inUse_d;
  logic [IDX-1:0]       tagPtr_q, tagPtr_d;

  assign reqCa    = in_request_address[CA-1:0];
  assign reqBank  = in_request_address[CA+BA-1:CA];
  assign reqRa    = in_request_address[CA+BA+RA-1:CA+BA];
  assign reqType  = r_type'(in_request_type);
  assign reqEntry = {in_request_data, tagPtr_q, reqRa, reqCa, reqType};

  // Busy never looks at ready: a pop on a full bank does not open a slot this cycle.
  assign out_busy = !rst_n || fifoFull[reqBank] || inUse_q[tagPtr_q];
  assign accept   = in_valid && !out_busy;

  always_comb begin
    inUse_d  = inUse_q;
    tagPtr_d = tagPtr_q;
    if (request_done_valid) begin
      inUse_d[index] = 1'b0;
    end
    if (accept) begin
      inUse_d[tagPtr_q] = 1'b1;
      tagPtr_d          = tagPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inUse_q  <= '0;
      tagPtr_q <= '0;
    end else begin
      inUse_q  <= inUse_d;
      tagPtr_q <= tagPtr_d;
    end
  end

`ifdef BANK_DISPATCH_TAG_ERR_EN
  logic tagErr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagErr_q <= 1'b0;
    end else if (request_done_valid && !inUse_q[index]) begin
      tagErr_q <= 1'b1;
    end
  end

  assign tag_err_o = tagErr_q;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept && (reqBank == BA'(b))),
      .pop_i   (ready[b]),
      .data_i  (reqEntry),
      .head_o  (head[b]),
      .full_o  (fifoFull[b]),
      .empty_o (fifoEmpty[b])
    );

    assign valid_o[b] = !fifoEmpty[b];
    assign {dq_o[b*DQ +: DQ], idx_o[b*IDX +: IDX], ra_o[b*RA +: RA],
            ca_o[b*CA +: CA], t_o[b]} = head[b];
  end

endmodule

// File: tb/tb_bank_dispatch_queue.sv
// Directed self-checking bench for bank_dispatch_queue at default parameters;
// define BANK_DISPATCH_TAG_ERR_EN to also exercise tag_err_o.
module tb_bank_dispatch_queue;

  localparam int NB  = 16;
  localparam int DQ  = 16;
  localparam int IDX = 6;
  localparam int RA  = 16;
  localparam int CA  = 10;
  localparam int AW  = RA + 4 + CA;

  logic              clk;
  logic              rst_n;
  logic              inValid;
  logic              inType;
  logic [DQ-1:0]     inData;
  logic [AW-1:0]     inAddr;
  logic              outBusy;
  logic              doneValid;
  logic [IDX-1:0]    doneIndex;
  logic [NB-1:0]     ready;
  logic [NB-1:0]     validO;
  logic [NB*DQ-1:0]  dqO;
  logic [NB*IDX-1:0] idxO;
  logic [NB*RA-1:0]  raO;
  logic [NB*CA-1:0]  caO;
  logic [NB-1:0]     tO;
`ifdef BANK_DISPATCH_TAG_ERR_EN
  logic              tagErr;
`endif

  int checkCount = 0;
  int passCount  = 0;

  bank_dispatch_queue dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (inValid),
    .in_request_type    (inType),
    .in_request_data    (inData),
    .in_request_address (inAddr),
    .out_busy           (outBusy),
    .request_done_valid (doneValid),
    .index              (doneIndex),
    .ready              (ready),
    .valid_o            (validO),
    .dq_o               (dqO),
    .idx_o              (idxO),
    .ra_o               (raO),
    .ca_o               (caO),
`ifdef BANK_DISPATCH_TAG_ERR_EN
    .t_o                (tO),
    .tag_err_o          (tagErr)
`else
    .t_o                (tO)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic t, input logic [DQ-1:0] d,
                               input logic [RA-1:0] ra, input logic [3:0] bank,
                               input logic [CA-1:0] ca);
    inValid = v;
    inType  = t;
    inData  = d;
    inAddr  = {ra, bank, ca};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    inValid   = 1'b0;
    inType    = 1'b0;
    inData    = '0;
    inAddr    = '0;
    doneValid = 1'b0;
    doneIndex = '0;
    ready     = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [IDX-1:0] headIdx(input int b);
    return idxO[b*IDX +: IDX];
  endfunction

  initial begin
    rst_n     = 1'b0;
    inValid   = 1'b0;
    inType    = 1'b0;
    inData    = '0;
    inAddr    = '0;
    doneValid = 1'b0;
    doneIndex = '0;
    ready     = '0;
    #2;
    checkOutput("reset busy", 64'(outBusy), 64'd1);
    checkOutput("reset valid", 64'(validO), 64'd0);
    checkOutput("reset idx", 64'(idxO[63:0]), 64'd0);
    applyReset();

    // Single READ to bank 3.
    applyStimulus(1'b1, 1'b0, 16'hBEEF, 16'h1234, 4'd3, 10'h2A);
    checkOutput("t1 busy at accept", 64'(outBusy), 64'd0);
    step();
    inValid = 1'b0;
    checkOutput("t1 valid3", 64'(validO[3]), 64'd1);
    checkOutput("t1 idx3", 64'(headIdx(3)), 64'd0);
    checkOutput("t1 ra3", 64'(raO[3*RA +: RA]), 64'h1234);
    checkOutput("t1 ca3", 64'(caO[3*CA +: CA]), 64'h2A);
    checkOutput("t1 t3", 64'(tO[3]), 64'd0);
    checkOutput("t1 dq3", 64'(dqO[3*DQ +: DQ]), 64'hBEEF);

    // Fill bank 5, fifth write stalls until a pop frees a slot.
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'hA000 + i), 16'(i), 4'd5, 10'(i));
      checkOutput("t2 busy fill", 64'(outBusy), 64'd0);
      step();
    end
    applyStimulus(1'b1, 1'b1, 16'hA004, 16'd4, 4'd5, 10'd4);
    checkOutput("t2 busy full", 64'(outBusy), 64'd1);
    checkOutput("t2 head0", 64'(headIdx(5)), 64'd0);
    ready[5] = 1'b1;
    checkOutput("t2 busy full with pop", 64'(outBusy), 64'd1);
    step();
    ready[5] = 1'b0;
    checkOutput("t2 busy after pop", 64'(outBusy), 64'd0);
    step();
    inValid = 1'b0;
    checkOutput("t2 head after pop", 64'(headIdx(5)), 64'd1);
    ready[5] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("t2 drain valid", 64'(validO[5]), 64'd1);
      checkOutput("t2 drain idx", 64'(headIdx(5)), 64'(k));
      checkOutput("t2 drain dq", 64'(dqO[5*DQ +: DQ]), 64'(16'hA000 + k));
      step();
    end
    checkOutput("t2 drained", 64'(validO[5]), 64'd0);
    ready[5] = 1'b0;

    // Exhaust the tag pool, then release tag 0.
    applyReset();
    ready = '1;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i), 16'(i), 4'(i % 16), 10'(i));
      checkOutput("t3 busy pool", 64'(outBusy), 64'd0);
      step();
    end
    ready = '0;
    applyStimulus(1'b1, 1'b0, 16'h0777, 16'h0777, 4'd7, 10'h077);
    checkOutput("t3 busy exhausted", 64'(outBusy), 64'd1);
    doneValid = 1'b1;
    doneIndex = 6'd0;
    checkOutput("t3 busy during release", 64'(outBusy), 64'd1);
    step();
    doneValid = 1'b0;
    checkOutput("t3 busy after release", 64'(outBusy), 64'd0);
    step();
    inValid = 1'b0;
    checkOutput("t3 valid7", 64'(validO[7]), 64'd1);
    checkOutput("t3 idx7", 64'(headIdx(7)), 64'd0);
    checkOutput("t3 ra7", 64'(raO[7*RA +: RA]), 64'h0777);

    // Concurrent push to bank 2 with pops on banks 0, 1 and 2.
    applyReset();
    applyStimulus(1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 10'd0);
    step();
    applyStimulus(1'b1, 1'b0, 16'd1, 16'd1, 4'd1, 10'd1);
    step();
    applyStimulus(1'b1, 1'b1, 16'd2, 16'd2, 4'd2, 10'd2);
    step();
    applyStimulus(1'b1, 1'b1, 16'd3, 16'd3, 4'd2, 10'd3);
    step();
    applyStimulus(1'b1, 1'b1, 16'd4, 16'd4, 4'd2, 10'd4);
    ready = 16'h0007;
    checkOutput("t4 busy", 64'(outBusy), 64'd0);
    step();
    inValid = 1'b0;
    ready   = '0;
    checkOutput("t4 valid0", 64'(validO[0]), 64'd0);
    checkOutput("t4 valid1", 64'(validO[1]), 64'd0);
    checkOutput("t4 hold idx1", 64'(headIdx(1)), 64'd1);
    checkOutput("t4 valid2", 64'(validO[2]), 64'd1);
    checkOutput("t4 head2 first", 64'(headIdx(2)), 64'd3);
    ready[2] = 1'b1;
    step();
    checkOutput("t4 head2 second", 64'(headIdx(2)), 64'd4);
    checkOutput("t4 valid2 second", 64'(validO[2]), 64'd1);
    step();
    checkOutput("t4 bank2 empty", 64'(validO[2]), 64'd0);
    ready = '0;

    // Asynchronous reset with entries queued.
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i), 16'(i), 4'd1, 10'(i));
      step();
    end
    inValid = 1'b0;
    checkOutput("t5 queued", 64'(validO[1]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 valid in reset", 64'(validO), 64'd0);
    checkOutput("t5 busy in reset", 64'(outBusy), 64'd1);
    checkOutput("t5 idx in reset", 64'(headIdx(1)), 64'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0009, 16'h0009, 4'd9, 10'd9);
    step();
    inValid = 1'b0;
    checkOutput("t5 new tag", 64'(headIdx(9)), 64'd0);
    checkOutput("t5 old bank empty", 64'(validO[1]), 64'd0);

`ifdef BANK_DISPATCH_TAG_ERR_EN
    applyReset();
    checkOutput("t6 err clear", 64'(tagErr), 64'd0);
    doneValid = 1'b1;
    doneIndex = 6'd9;
    step();
    doneValid = 1'b0;
    checkOutput("t6 err set", 64'(tagErr), 64'd1);
    step();
    step();
    checkOutput("t6 err sticky", 64'(tagErr), 64'd1);
    applyReset();
    checkOutput("t6 err reset", 64'(tagErr), 64'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bank_dispatch_queue.md
Name: bank_dispatch_queue

Overview:
Parametrised request dispatcher for the memory controller front end, generalising the fixed 16-bank front end to NUM_BANKS banks with per-bank buffering depth DEPTH. It accepts one host request per cycle, decodes the address into bank/row/column, assigns a unique transaction index from a 2^IDX tag pool, and queues the request in the target bank's FIFO. Each bank FIFO drains to its bank scheduler over a valid/ready handshake. Tags are returned through the completion port.

Parameters:
NUM_BANKS, 16, number of bank channels (power of 2, ≥2)
BA, $clog2(NUM_BANKS), bank field width (derived localparam)
DEPTH, 4, entries per bank FIFO (power of 2, ≥2)
CA, 10, column address width
RA, 16, row address width
DQ, 16, data width
IDX, 6, tag width; pool holds 2^IDX tags

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  host request valid
in_request_type  in  1  0=READ, 1=WRITE (r_type)
in_request_data  in  DQ  write data; ignored for reads but still stored
in_request_address  in  RA+BA+CA  {ra, bank, ca}, with ca in the LSBs
out_busy  out  1  request cannot be accepted this cycle
request_done_valid  in  1  completion strobe
index  in  IDX  tag being released
ready  in  NUM_BANKS  per-bank scheduler ready
valid_o  out  NUM_BANKS  per-bank head valid
dq_o  out  NUM_BANKS×DQ  head data
idx_o  out  NUM_BANKS×IDX  head tag
ra_o  out  NUM_BANKS×RA  head row
ca_o  out  NUM_BANKS×CA  head column
t_o  out  NUM_BANKS  head type

Behaviour:
- Reset (asynchronous, rst_n low):
  - All FIFOs empty; valid_o=0; dq_o/idx_o/ra_o/ca_o/t_o=0.
  - Tag bitmap cleared; tag pointer=0.
  - out_busy=1 while rst_n is low.
- Decode:
  - bank = addr[CA+BA-1:CA]
  - ca = addr[CA-1:0]
  - ra = addr[CA+BA+RA-1:CA+BA]
- out_busy is combinational: !rst_n | fifo_full[bank] | inuse[tag_ptr]. It never depends on ready, so there is no ready→busy combinational path.
- Accept: in_valid & !out_busy at rising edge N.
  - Entry {data, tag_ptr, ra, ca, type} is written to FIFO[bank].
  - inuse[tag_ptr] is set.
  - tag_ptr increments, wrapping from 2^IDX-1 to 0.
- Push latency: an accepted entry is visible at its bank head in cycle N+1. FIFOs are show-ahead; head outputs are driven from registered storage.
- Pop: valid_o[b] & ready[b] at an edge removes the head. The next entry appears the following cycle with no bubble.
- Full FIFO: busy for that bank even if a pop happens in the same cycle. No push is lost.
- Empty FIFO: valid_o=0 and the head outputs hold their last value. ready is don't-care.
- Simultaneous pops on multiple banks and one push to any bank are allowed in the same cycle. Push and pop on the same non-full bank in one cycle keep the count unchanged.
- Release: request_done_valid at an edge clears inuse[index].
  - A release and an allocation of the same tag in one cycle: the allocation sees the pre-release bitmap (busy); the tag is free next cycle.
  - Release of a tag that is not in use is ignored.
- Tag allocation is strictly sequential. The pool stalls at the first in-use tag; it does not skip ahead.
- Reset mid-operation: all queued entries and tags are discarded immediately. There are no partial pops.
- Counters: FIFO pointers are $clog2(DEPTH)+1 bits, with wrap detected on the MSB.

Optional Feature:
Macro BANK_DISPATCH_TAG_ERR_EN.
- Defined: adds output tag_err_o (1 bit), sticky and cleared only by reset. It is set the cycle after a release of an index whose inuse bit is 0.
- Undefined: no tag_err_o port; such releases are silently ignored.

Decomposition:
- Shared package types_def:
  - r_type enum (READ=0, WRITE=1)
  - bank_entry_t packed struct {dq, idx, ra, ca, t}, parameterised via package localparams for DQ/IDX/RA/CA defaults
- Natural sub-module: bank_fifo (one show-ahead FIFO of bank_entry_t, depth DEPTH, push/pop/full/empty), instantiated NUM_BANKS times via generate.
- Tag bitmap, pointer, decode and busy logic live in the top.

Test Plan:
1. Reset release, then one READ to addr with bank=3, ra=0x1234, ca=0x2A, ready=0 → out_busy=0 at accept; valid_o[3]=1 next cycle; idx_o[3]=0, ra_o[3]=0x1234, ca_o[3]=0x2A, t_o[3]=0.
2. Five WRITEs to bank 5 (DEPTH=4) with ready[5]=0 → four accepted with tags 0..3. out_busy=1 on the fifth; after one pop, the fifth is accepted next cycle with tag 4.
3. 64 requests spread over banks with all ready=1 and no completions → the 65th sees out_busy=1 (inuse[0]). Release index=0 → accept the following cycle with tag 0.
4. In one cycle, push to bank 2 while banks 0, 1 and 2 pop; bank 2 holds 2 entries → counts: bank 2 stays 2, banks 0 and 1 decrement; FIFO order preserved.
5. Assert rst_n low mid-stream with 3 entries queued → valid_o=0 immediately; after release, the first new request gets tag 0.
6. With BANK_DISPATCH_TAG_ERR_EN defined, release index=9 while it is unallocated → tag_err_o=1 the next cycle and stays 1 until reset.
